decoder_4to16: RTL and testbench
================================

# decoder_4to16

- Enabled one-hot binary decoder family: `decoder1_2` (1-to-2) and `decoder4_16` (4-to-16), plus an optional registered copy of the 16-bit output.
- Used by the piano key/note select path, where wider decoders (e.g. 5-to-32) are composed as:
  - two `decoder4_16` instances driven by `in[3:0]`;
  - one `decoder1_2` on the MSB, whose outputs drive the two instances' `enable` pins.
- Decode is purely combinational. The registered output exists so that downstream logic can consume a glitch-free, reset-defined one-hot vector.

## Interface
Parameters:
- `OUT_REG`, default 1: 1 gives a registered `out_q`; 0 makes `out_q` a combinational copy of `out`.

Ports of `decoder4_16` (clock and reset first):
- `clk`  input  1  system clock; rising edge active.
- `reset_n`  input  1  reset, asynchronous, active-low.
- `in`  input  4  binary select index.
- `enable`  input  1  decode enable, active-high.
- `out`  output  16  combinational one-hot decode.
- `out_q`  output  16  registered decode (see Timing).

Ports of `decoder1_2`:
- `in`  input  1  select bit.
- `enable`  input  1  decode enable, active-high.
- `out`  output  2  one-hot decode; `out[0]` is selected when `in`=0, `out[1]` when `in`=1.

## Operation
`decoder1_2`:
- `out` = 2'b01 when `enable`=1 and `in`=0.
- `out` = 2'b10 when `enable`=1 and `in`=1.
- `out` = 2'b00 when `enable`=0, regardless of `in`.

`decoder4_16`:
- When `enable`=1: `out[k]`=1 exactly for k = `in` (unsigned); all other bits are 0.
- When `enable`=0: `out` = 16'h0000.
- Invariants: `out` is never multi-hot; `$countones(out)` = `enable`.
- X/Z on `in` while `enable`=0 must not propagate: `out` stays 0.
- Composition rule: feeding the two outputs of one `decoder1_2` into the enables of two `decoder4_16` instances yields a correct 5-to-32 decoder. Bit `in[4]`=1 selects the upper 16 outputs.

## Timing
- `out`: zero-cycle combinational path from `in` and `enable`; no latches.
- `out_q` with `OUT_REG`=1:
  - Captures `out` on each rising `clk`, giving 1-cycle latency.
  - `reset_n`=0 forces `out_q`=16'h0000 immediately, without waiting for a clock edge.
  - `out_q` holds 0 while `reset_n` is low.
  - The first capture happens on the first rising edge after `reset_n` deasserts.
- Reset asserted mid-operation: `out_q` clears asynchronously. The combinational `out` is unaffected by reset.
- `out_q` with `OUT_REG`=0: `out_q` = `out`; `clk` and `reset_n` are unused.
- No handshake and no internal state beyond the `out_q` register.

## Structure
- Shared package `decoder_pkg`:
  - `localparam` `DEC_IN_W`=4 and `DEC_OUT_W`=16;
  - typedef `onehot16_t` (logic [15:0]).
- Sub-module `decoder1_2` is the natural leaf cell. `decoder4_16` is built from it as a 4-level tree of 15 `decoder1_2` instances:
  - The root instance takes `in[3]` and top-level `enable`.
  - Each level below takes the next lower input bit: `in[2]`, then `in[1]`, then `in[0]`.
  - Each child's `enable` is one output of its parent.
  - Leaf outputs concatenate in index order to form `out`.
- A `generate` loop for the tree is permitted. `out_q` is one `always_ff` gated by `OUT_REG`.

## Test plan
- `decoder1_2` exhaustive, all 4 combinations of {`enable`,`in`}: {0,x} -> 2'b00; {1,0} -> 2'b01; {1,1} -> 2'b10.
- `decoder4_16` exhaustive sweep of {`enable`,`in`} = 0..31, one value per 10 time units:
  - for j<16: `out`=0;
  - for j>=16: `out` = 1<<(j-16), e.g. j=21 gives `out`=16'h0020;
  - assert the one-hot invariant on every step.
- Composition: two `decoder4_16` instances plus one `decoder1_2` swept over 64 values of {`enable`,`in[4:0]`}:
  - {1,5'd17} -> 32'h0002_0000;
  - {1,5'd3} -> 32'h0000_0008;
  - any value with `enable`=0 -> 0.
- Registered path:
  - Set `enable`=1, `in`=4'hF, and hold `reset_n` low: `out_q`=0.
  - Release reset: after the next rising edge, `out_q`=16'h8000.
  - Change `in` to 4'h0: `out_q` stays 16'h8000 until the following edge, then becomes 16'h0001.
- Async reset mid-run: with `out_q`=16'h0010, drop `reset_n` between clock edges. `out_q` must read 0 before the next edge while `out` still reads 16'h0010.
- X-isolation: `enable`=0 with `in`=4'bxxxx gives `out`=16'h0000.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared widths and types for the one-hot decoder family.
package decoder_pkg;
    localparam int unsigned DEC_IN_W  = 4;
    localparam int unsigned DEC_OUT_W = 16;

    typedef logic [DEC_OUT_W-1:0] onehot16_t;
endpackage

// File: rtl/decoder_4to16_dec1_2.sv
// 1-to-2 enabled one-hot decoder; leaf cell of the wider decoder trees.
module decoder1_2 (
    input  logic       in,
    input  logic       enable,
    output logic [1:0] out
);
    // AND with enable so an unknown select cannot leak out while disabled
    assign out = {enable & in, enable & ~in};
endmodule

// File: rtl/decoder_4to16.sv
// 4-to-16 enabled one-hot decoder built as a tree of 1-to-2 cells,
// with an optional reset-defined registered copy of the output.
module decoder_4to16
    import decoder_pkg::*;
#(
    parameter bit OUT_REG = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DEC_IN_W-1:0]  in,
    input  logic                 enable,
    output logic [DEC_OUT_W-1:0] out,
    output logic [DEC_OUT_W-1:0] out_q
);
    // Heap-indexed enables: node n drives en[2n] and en[2n+1]; en[16..31] are the leaves.
    logic [2*DEC_OUT_W-1:1] en;

    assign en[1] = enable;

    for (genvar l = 0; l < DEC_IN_W; l++) begin : g_level
        for (genvar k = 0; k < (1 << l); k++) begin : g_node
            localparam int N = (1 << l) + k;
            decoder1_2 u_dec (
                .in     (in[DEC_IN_W-1-l]),
                .enable (en[N]),
                .out    (en[2*N+1:2*N])
            );
        end
    end

    assign out = en[2*DEC_OUT_W-1:DEC_OUT_W];

    if (OUT_REG) begin : g_reg
        onehot16_t out_r;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) out_r <= '0;
            else          out_r <= out;
        end

        assign out_q = out_r;
    end else begin : g_comb
        assign out_q = out;
    end
endmodule

// File: tb/tb_decoder_4to16.sv
// Directed self-checking bench for decoder1_2, decoder_4to16 and a 5-to-32 composition.
module tb_decoder_4to16;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  dut_in;
    logic        dut_en;
    logic [15:0] out, out_q;

    logic        d12_in, d12_en;
    logic [1:0]  d12_out;

    logic [4:0]  cmp_in;
    logic        cmp_en;
    logic [1:0]  msb_en;
    logic [15:0] lo_out, hi_out, lo_q, hi_q;
    logic [31:0] cmp_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decoder_4to16 #(.OUT_REG(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .in(dut_in), .enable(dut_en),
        .out(out), .out_q(out_q)
    );

    decoder1_2 u_d12 (.in(d12_in), .enable(d12_en), .out(d12_out));

    decoder1_2 u_msb (.in(cmp_in[4]), .enable(cmp_en), .out(msb_en));
    decoder_4to16 #(.OUT_REG(1'b0)) u_lo (
        .clk(clk), .reset_n(reset_n), .in(cmp_in[3:0]), .enable(msb_en[0]),
        .out(lo_out), .out_q(lo_q)
    );
    decoder_4to16 #(.OUT_REG(1'b0)) u_hi (
        .clk(clk), .reset_n(reset_n), .in(cmp_in[3:0]), .enable(msb_en[1]),
        .out(hi_out), .out_q(hi_q)
    );
    assign cmp_out = {hi_out, lo_out};

    task automatic test_reset();
        reset_n = 1'b0;
        dut_en  = 1'b1;
        dut_in  = 4'hF;
        #1;
        n_cmp++;
        if (out_q !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_async: out_q=%h expected=%h", out_q, 16'h0000);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (out_q !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_hold: out_q=%h expected=%h", out_q, 16'h0000);
        end
        n_cmp++;
        if (out !== 16'h8000) begin
            n_fail++;
            $display("FAIL reset_comb: out=%h expected=%h", out, 16'h8000);
        end
    endtask

    task automatic test_dec1_2();
        logic [1:0] exp_tab [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
        for (int i = 0; i < 4; i++) begin
            d12_en = i[1];
            d12_in = i[0];
            #1;
            n_cmp++;
            if (d12_out !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL dec1_2 en=%b in=%b: out=%b expected=%b",
                         d12_en, d12_in, d12_out, exp_tab[i]);
            end
        end
    endtask

    task automatic test_sweep();
        logic [15:0] exp;
        for (int j = 0; j < 32; j++) begin
            dut_en = j[4];
            dut_in = j[3:0];
            #5;
            exp = (j < 16) ? 16'h0000 : (16'h0001 << (j - 16));
            n_cmp++;
            if (out !== exp) begin
                n_fail++;
                $display("FAIL sweep j=%0d: out=%h expected=%h", j, out, exp);
            end
            n_cmp++;
            if ($countones(out) !== int'(dut_en)) begin
                n_fail++;
                $display("FAIL onehot j=%0d: ones=%0d expected=%0d", j, $countones(out), dut_en);
            end
            #5;
        end
        dut_en = 1'b1;
        dut_in = 4'd5;
        #1;
        n_cmp++;
        if (out !== 16'h0020) begin
            n_fail++;
            $display("FAIL sweep_j21: out=%h expected=%h", out, 16'h0020);
        end
    endtask

    task automatic test_compose();
        logic [31:0] exp;
        for (int v = 0; v < 64; v++) begin
            cmp_en = v[5];
            cmp_in = v[4:0];
            #1;
            exp = v[5] ? (32'h1 << v[4:0]) : 32'h0;
            n_cmp++;
            if (cmp_out !== exp) begin
                n_fail++;
                $display("FAIL compose v=%0d: out=%h expected=%h", v, cmp_out, exp);
            end
        end
        cmp_en = 1'b1;
        cmp_in = 5'd17;
        #1;
        n_cmp++;
        if (cmp_out !== 32'h0002_0000) begin
            n_fail++;
            $display("FAIL compose_17: out=%h expected=%h", cmp_out, 32'h0002_0000);
        end
        cmp_in = 5'd3;
        #1;
        n_cmp++;
        if (cmp_out !== 32'h0000_0008) begin
            n_fail++;
            $display("FAIL compose_3: out=%h expected=%h", cmp_out, 32'h0000_0008);
        end
    endtask

    task automatic test_reg_path();
        @(negedge clk);
        reset_n = 1'b0;
        dut_en  = 1'b1;
        dut_in  = 4'hF;
        @(negedge clk);
        n_cmp++;
        if (out_q !== 16'h0000) begin
            n_fail++;
            $display("FAIL reg_in_reset: out_q=%h expected=%h", out_q, 16'h0000);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_q !== 16'h8000) begin
            n_fail++;
            $display("FAIL reg_first: out_q=%h expected=%h", out_q, 16'h8000);
        end
        @(negedge clk);
        dut_in = 4'h0;
        #1;
        n_cmp++;
        if (out_q !== 16'h8000) begin
            n_fail++;
            $display("FAIL reg_hold: out_q=%h expected=%h", out_q, 16'h8000);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_q !== 16'h0001) begin
            n_fail++;
            $display("FAIL reg_next: out_q=%h expected=%h", out_q, 16'h0001);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        dut_in = 4'h4;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_q !== 16'h0010) begin
            n_fail++;
            $display("FAIL async_pre: out_q=%h expected=%h", out_q, 16'h0010);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (out_q !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_clear: out_q=%h expected=%h", out_q, 16'h0000);
        end
        n_cmp++;
        if (out !== 16'h0010) begin
            n_fail++;
            $display("FAIL async_comb: out=%h expected=%h", out, 16'h0010);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_q !== 16'h0010) begin
            n_fail++;
            $display("FAIL async_recover: out_q=%h expected=%h", out_q, 16'h0010);
        end
    endtask

    task automatic test_x_isolation();
        dut_en = 1'b0;
        dut_in = 4'bxxxx;
        d12_en = 1'b0;
        d12_in = 1'bx;
        #1;
        n_cmp++;
        if (out !== 16'h0000) begin
            n_fail++;
            $display("FAIL x_iso_4to16: out=%h expected=%h", out, 16'h0000);
        end
        n_cmp++;
        if (d12_out !== 2'b00) begin
            n_fail++;
            $display("FAIL x_iso_1to2: out=%b expected=%b", d12_out, 2'b00);
        end
        dut_in = 4'h0;
    endtask

    initial begin
        reset_n = 1'b0;
        dut_in  = 4'h0;
        dut_en  = 1'b0;
        d12_in  = 1'b0;
        d12_en  = 1'b0;
        cmp_in  = 5'd0;
        cmp_en  = 1'b0;

        test_reset();
        test_dec1_2();
        test_sweep();
        test_compose();
        test_reg_path();
        test_async_reset();
        test_x_isolation();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
